// File: rtl/pcie_msi_gen.sv
// pcie_msi_gen: turns per-vector interrupt requests into one-at-a-time MSI
// requests toward the PCIe core. Vectors are picked round-robin. A failed or
// timed-out delivery puts its vector back in pending and waits out a back-off
// period before the next issue.
module pcie_msi_gen #(
   parameter int RETRY_DELAY  = 16,
   parameter int WAIT_TIMEOUT = 1024
) (
   input  logic        clk_user,
   input  logic        rst_user_n,
   input  logic [31:0] irq_in,
   input  logic [3:0]  cfg_interrupt_msi_enable,
   input  logic [11:0] cfg_interrupt_msi_mmenable,
   input  logic        cfg_interrupt_msi_sent,
   input  logic        cfg_interrupt_msi_fail,
   output logic [31:0] cfg_interrupt_msi_int,
   output logic [3:0]  cfg_interrupt_msi_select,
   output logic [31:0] cfg_interrupt_msi_pending_status,
   output logic [3:0]  cfg_interrupt_msi_function_number,
   output logic [31:0] irq_pending,
   output logic        busy,
   output logic [15:0] msi_sent_count,
   output logic [15:0] msi_fail_count
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BACKOFF} state_t;

   // Last timer value before a WAIT timeout, and before BACKOFF ends.
   localparam logic [31:0] WAIT_LAST    = 32'(WAIT_TIMEOUT - 1);
   localparam logic [31:0] BACKOFF_LAST = 32'(RETRY_DELAY - 1);

   state_t      state_q, state_d;
   logic [31:0] pending_q, pending_d;
   logic [4:0]  last_q, last_d;
   logic [4:0]  in_flight_q, in_flight_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] msi_int_q, msi_int_d;
   logic [15:0] sent_cnt_q, sent_cnt_d;
   logic [15:0] fail_cnt_q, fail_cnt_d;

   logic [2:0]  mm;
   logic [31:0] elig_mask;
   logic [31:0] eligible;
   logic [31:0] issue_clr;
   logic [31:0] fail_set;
   logic        sel_found;
   logic [4:0]  sel_vec;
   logic [4:0]  cand;

   // Only PF0 fields of the core's config vectors are used.
   logic unused_cfg_bits;
   assign unused_cfg_bits = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

   // Eligible vectors: pending bits below the granted count 2^mm (mm capped at 5).
   always_comb begin
      mm = (cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 3'd5 : cfg_interrupt_msi_mmenable[2:0];
      elig_mask = '0;
      for (int i = 0; i < 32; i++) begin
         elig_mask[i] = (i < (1 << mm));
      end
      eligible = pending_q & elig_mask;
   end

   // Round-robin pick: first eligible vector searching upward from last_issued+1.
   always_comb begin
      sel_found = 1'b0;
      sel_vec   = last_q;
      cand      = last_q;
      for (int k = 1; k <= 32; k++) begin
         cand = last_q + k[4:0];
         if (!sel_found && eligible[cand]) begin
            sel_found = 1'b1;
            sel_vec   = cand;
         end
      end
   end

   // Next-state, issue/retry bookkeeping and pending-register update.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      last_d      = last_q;
      in_flight_d = in_flight_q;
      msi_int_d   = '0;
      sent_cnt_d  = sent_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      issue_clr   = '0;
      fail_set    = '0;
      case (state_q)
         ST_IDLE: begin
            if (cfg_interrupt_msi_enable[0] && sel_found) begin
               msi_int_d   = 32'd1 << sel_vec;
               issue_clr   = 32'd1 << sel_vec;
               last_d      = sel_vec;
               in_flight_d = sel_vec;
               timer_d     = '0;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // sent wins over a simultaneous fail
            if (cfg_interrupt_msi_sent) begin
               sent_cnt_d = sent_cnt_q + 16'd1;
               timer_d    = '0;
               state_d    = ST_IDLE;
            end else if (cfg_interrupt_msi_fail || (timer_q == WAIT_LAST)) begin
               fail_set = 32'd1 << in_flight_q;
               if (fail_cnt_q != 16'hFFFF) begin
                  fail_cnt_d = fail_cnt_q + 16'd1;
               end
               timer_d = '0;
               state_d = ST_BACKOFF;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         ST_BACKOFF: begin
            if (timer_q == BACKOFF_LAST) begin
               timer_d = '0;
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
      // New requests and retries win over the issue clear.
      pending_d = (pending_q & ~issue_clr) | irq_in | fail_set;
   end

   // State and datapath registers; reset drops any in-flight request.
   always_ff @(posedge clk_user or negedge rst_user_n) begin
      if (!rst_user_n) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         last_q      <= 5'd31;
         in_flight_q <= '0;
         timer_q     <= '0;
         msi_int_q   <= '0;
         sent_cnt_q  <= '0;
         fail_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         last_q      <= last_d;
         in_flight_q <= in_flight_d;
         timer_q     <= timer_d;
         msi_int_q   <= msi_int_d;
         sent_cnt_q  <= sent_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
      end
   end

   assign cfg_interrupt_msi_int             = msi_int_q;
   assign cfg_interrupt_msi_select          = 4'd0;
   assign cfg_interrupt_msi_pending_status  = 32'd0;
   assign cfg_interrupt_msi_function_number = 4'd0;
   assign irq_pending                       = pending_q;
   assign busy                              = (state_q != ST_IDLE);
   assign msi_sent_count                    = sent_cnt_q;
   assign msi_fail_count                    = fail_cnt_q;

endmodule

// File: tb/tb_pcie_msi_gen.sv
// Bench for pcie_msi_gen: directed scenarios with hand-computed expectations,
// then random traffic, all compared every cycle against a behavioural model.
module tb_pcie_msi_gen;
   localparam int RD = 16;
   localparam int WT = 1024;

   logic        clk_user = 1'b0;
   logic        rst_user_n = 1'b0;
   logic [31:0] irq_in = '0;
   logic [3:0]  cfg_interrupt_msi_enable = '0;
   logic [11:0] cfg_interrupt_msi_mmenable = '0;
   logic        cfg_interrupt_msi_sent = 1'b0;
   logic        cfg_interrupt_msi_fail = 1'b0;
   logic [31:0] cfg_interrupt_msi_int;
   logic [3:0]  cfg_interrupt_msi_select;
   logic [31:0] cfg_interrupt_msi_pending_status;
   logic [3:0]  cfg_interrupt_msi_function_number;
   logic [31:0] irq_pending;
   logic        busy;
   logic [15:0] msi_sent_count;
   logic [15:0] msi_fail_count;

   pcie_msi_gen #(.RETRY_DELAY(RD), .WAIT_TIMEOUT(WT)) dut (
      .clk_user(clk_user),
      .rst_user_n(rst_user_n),
      .irq_in(irq_in),
      .cfg_interrupt_msi_enable(cfg_interrupt_msi_enable),
      .cfg_interrupt_msi_mmenable(cfg_interrupt_msi_mmenable),
      .cfg_interrupt_msi_sent(cfg_interrupt_msi_sent),
      .cfg_interrupt_msi_fail(cfg_interrupt_msi_fail),
      .cfg_interrupt_msi_int(cfg_interrupt_msi_int),
      .cfg_interrupt_msi_select(cfg_interrupt_msi_select),
      .cfg_interrupt_msi_pending_status(cfg_interrupt_msi_pending_status),
      .cfg_interrupt_msi_function_number(cfg_interrupt_msi_function_number),
      .irq_pending(irq_pending),
      .busy(busy),
      .msi_sent_count(msi_sent_count),
      .msi_fail_count(msi_fail_count)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk_user = ~clk_user;

   int cyc = 0;
   always @(posedge clk_user) cyc++;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Model phases: 0 idle, 1 awaiting sent/fail, 2 backing off.
   logic [31:0] m_pend, m_int;
   int          m_sent, m_fail, m_last, m_infl, m_phase, m_age, m_left;

   always @(posedge clk_user or negedge rst_user_n) begin
      logic [31:0] clr, setv, elig;
      int          lim, mmc, v;
      bit          found;
      if (!rst_user_n) begin
         m_pend = '0; m_int = '0; m_sent = 0; m_fail = 0;
         m_last = 31; m_infl = 0; m_phase = 0; m_age = 0; m_left = 0;
      end else begin
         clr = '0; setv = '0; m_int = '0;
         if (m_phase == 0) begin
            mmc = (cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 5 : int'(cfg_interrupt_msi_mmenable[2:0]);
            lim = 2 ** mmc;
            elig = '0;
            for (int i = 0; i < 32; i++) if (i < lim) elig[i] = m_pend[i];
            if (cfg_interrupt_msi_enable[0] && elig != 0) begin
               found = 1'b0;
               for (int k = 1; k <= 32; k++) begin
                  v = (m_last + k) % 32;
                  if (!found && elig[v]) begin found = 1'b1; m_last = v; end
               end
               m_int = 32'(1) << m_last;
               clr = m_int;
               m_infl = m_last;
               m_phase = 1;
               m_age = 0;
            end
         end else if (m_phase == 1) begin
            m_age++;
            if (cfg_interrupt_msi_sent) begin
               m_sent = (m_sent + 1) % 65536;
               m_phase = 0;
            end else if (cfg_interrupt_msi_fail || m_age == WT) begin
               setv[m_infl] = 1'b1;
               if (m_fail < 65535) m_fail++;
               m_phase = 2;
               m_left = RD;
            end
         end else begin
            m_left--;
            if (m_left == 0) m_phase = 0;
         end
         m_pend = (m_pend & ~clr) | irq_in | setv;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk_user) begin
      if (cmp_on) begin
         chk("msi_int", cfg_interrupt_msi_int, m_int);
         chk("irq_pending", irq_pending, m_pend);
         chk("busy", 32'(busy), 32'(m_phase != 0));
         chk("sent_count", 32'(msi_sent_count), 32'(m_sent));
         chk("fail_count", 32'(msi_fail_count), 32'(m_fail));
         chk("constants", {cfg_interrupt_msi_select, cfg_interrupt_msi_function_number},
             32'd0 | cfg_interrupt_msi_pending_status);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk_user);
      #2;
   endtask

   task automatic do_reset();
      rst_user_n = 1'b0;
      step();
      step();
      rst_user_n = 1'b1;
      step();
   endtask

   // Drive irq_in for one edge; returns the cycle number of the sampling edge.
   task automatic pulse_irq(input logic [31:0] m, output int e);
      irq_in = m;
      step();
      e = cyc;
      irq_in = '0;
   endtask

   task automatic respond(input bit s, input bit f, output int e);
      cfg_interrupt_msi_sent = s;
      cfg_interrupt_msi_fail = f;
      step();
      e = cyc;
      cfg_interrupt_msi_sent = 1'b0;
      cfg_interrupt_msi_fail = 1'b0;
   endtask

   // Bounded wait for an MSI pulse; returns it and the cycle it was seen in.
   task automatic wait_issue(input int budget, output logic [31:0] v, output int at);
      bit seen;
      seen = 1'b0;
      v = '0;
      at = cyc;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk_user);
         if (cfg_interrupt_msi_int != 0) begin
            seen = 1'b1;
            v = cfg_interrupt_msi_int;
            at = cyc;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL issue_timeout: no msi_int within %0d cycles (cycle %0d)", budget, cyc);
      end
      step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] v;
      int e, at, at2, f, s;

      cmp_on = 1'b1;
      do_reset();
      chk("rst_pending", irq_pending, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_counts", {msi_sent_count, msi_fail_count}, 32'd0);

      // Single vector, latency and single-cycle pulse.
      cfg_interrupt_msi_enable = 4'h1;
      cfg_interrupt_msi_mmenable = 12'd5;
      step();
      pulse_irq(32'h1, e);
      wait_issue(20, v, at);
      chk("s1_vec", v, 32'h1);
      chk("s1_latency", 32'(at - e), 32'd1);
      chk("s1_one_cycle", cfg_interrupt_msi_int, 32'd0);
      respond(1'b1, 1'b0, s);
      chk("s1_sent_count", 32'(msi_sent_count), 32'd1);
      chk("s1_pending", irq_pending, 32'd0);

      // Two vectors from one pulse, issued 0 then 2, no overlap with sent.
      do_reset();
      pulse_irq(32'h5, e);
      wait_issue(20, v, at);
      chk("s2_first", v, 32'h1);
      step(); step(); step();
      chk("s2_busy_wait", 32'(busy), 32'd1);
      respond(1'b1, 1'b0, s);
      wait_issue(20, v, at2);
      chk("s2_second", v, 32'h4);
      chk("s2_no_overlap", 32'(at2 > s), 32'd1);
      respond(1'b1, 1'b0, s);

      // Fail on vector 3: retry after back-off.
      pulse_irq(32'h8, e);
      wait_issue(20, v, at);
      chk("s3_vec", v, 32'h8);
      respond(1'b0, 1'b1, f);
      chk("s3_fail_count", 32'(msi_fail_count), 32'd1);
      chk("s3_pending", irq_pending, 32'h8);
      wait_issue(100, v, at2);
      chk("s3_retry_vec", v, 32'h8);
      chk("s3_retry_gap", 32'((at2 - f) >= RD + 1 && (at2 - f) <= RD + 2), 32'd1);
      respond(1'b1, 1'b0, s);

      // Ineligible vector held until the grant widens.
      cfg_interrupt_msi_mmenable = 12'd1;
      pulse_irq(32'h4, e);
      for (int i = 0; i < 10; i++) step();
      chk("s4_held", irq_pending, 32'h4);
      chk("s4_idle", 32'(busy), 32'd0);
      cfg_interrupt_msi_mmenable = 12'd2;
      wait_issue(20, v, at);
      chk("s4_vec", v, 32'h4);
      respond(1'b1, 1'b0, s);

      // Timeout retried, then reset mid-WAIT discards the request.
      cfg_interrupt_msi_mmenable = 12'd5;
      pulse_irq(32'h80, e);
      wait_issue(20, v, at);
      wait_issue(WT + RD + 50, v, at2);
      chk("s5_retry_vec", v, 32'h80);
      chk("s5_fail_count", 32'(msi_fail_count), 32'd2);
      chk("s5_gap", 32'((at2 - at) >= WT + RD && (at2 - at) <= WT + RD + 2), 32'd1);
      step(); step();
      rst_user_n = 1'b0;
      #1;
      chk("s5_rst_outs", irq_pending | cfg_interrupt_msi_int, 32'd0);
      chk("s5_rst_cnt", {msi_sent_count, msi_fail_count}, 32'd0);
      chk("s5_rst_busy", 32'(busy), 32'd0);
      chk("s5_rst_const", cfg_interrupt_msi_pending_status, 32'd0);
      step();
      rst_user_n = 1'b1;
      step();
      respond(1'b1, 1'b0, s);
      respond(1'b0, 1'b1, f);
      chk("s5_post_sent", 32'(msi_sent_count), 32'd0);
      chk("s5_post_fail", 32'(msi_fail_count), 32'd0);
      chk("s5_post_busy", 32'(busy), 32'd0);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         irq_in = ($urandom_range(0, 7) == 0) ? ($urandom & $urandom & $urandom) : 32'd0;
         if ($urandom_range(0, 60) == 0) cfg_interrupt_msi_enable = ($urandom_range(0, 3) != 0) ? 4'h1 : 4'h0;
         if ($urandom_range(0, 60) == 0) cfg_interrupt_msi_mmenable = 12'($urandom_range(0, 7));
         cfg_interrupt_msi_sent = ($urandom_range(0, 5) == 0);
         cfg_interrupt_msi_fail = ($urandom_range(0, 12) == 0);
         step();
      end
      irq_in = '0;
      cfg_interrupt_msi_sent = 1'b0;
      cfg_interrupt_msi_fail = 1'b0;
      step();
      step();
      cmp_on = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcie_msi_gen.md
PCIE_MSI_GEN -- requirements
Module: pcie_msi_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- RETRY_DELAY, 16, idle cycles after a failed or timed-out MSI before the next issue
- WAIT_TIMEOUT, 1024, cycles in WAIT without sent/fail before the request counts as failed
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk_user, in, 1, user clock (250 MHz PCIe core user clock)
- rst_user_n, in, 1, reset, asynchronous, active-low
- irq_in, in, 32, per-vector interrupt request; a high bit on any rising edge requests that vector
- cfg_interrupt_msi_enable, in, 4, from core; bit 0 = MSI enabled for PF0
- cfg_interrupt_msi_mmenable, in, 12, from core; bits [2:0] = log2 of granted vector count for PF0
- cfg_interrupt_msi_sent, in, 1, from core; MSI delivered
- cfg_interrupt_msi_fail, in, 1, from core; MSI not delivered
- cfg_interrupt_msi_int, out, 32, to core; one-hot MSI request pulse
- cfg_interrupt_msi_select, out, 4, to core; constant 4'd0
- cfg_interrupt_msi_pending_status, out, 32, to core; constant 32'd0
- cfg_interrupt_msi_function_number, out, 4, to core; constant 4'd0
- irq_pending, out, 32, current pending-vector register
- busy, out, 1, high when the FSM is not in IDLE
- msi_sent_count, out, 16, delivered-MSI counter, wraps at 2^16
- msi_fail_count, out, 16, failed-or-timed-out counter, saturates at 16'hFFFF
REQ-003 The design SHALL use one clock, clk_user; rst_user_n SHALL be asynchronous and active-low.

Function
REQ-004 Pending update every edge SHALL be: pending <= (pending & ~issue_clr) | irq_in | fail_set; set has priority over clear.
REQ-005 The FSM SHALL have states IDLE, WAIT and BACKOFF.
REQ-006 The eligible mask SHALL be pending bits with index < 2^mm, where mm = mmenable[2:0] clamped to 5.
REQ-007 In IDLE, when msi_enable[0]=1 and the eligible mask is non-zero, the FSM SHALL select vector v by round-robin starting at (last_issued+1) mod 32; last_issued resets to 31.
REQ-008 On selection: cfg_interrupt_msi_int = onehot(v) for exactly one cycle; pending[v] cleared (issue_clr); v stored as in_flight; go to WAIT.
REQ-009 Latency: irq_in sampled at edge E with the FSM idle and MSI enabled SHALL put msi_int high in the cycle after edge E+1.
REQ-010 In WAIT, sent=1 SHALL increment msi_sent_count and return the FSM to IDLE.
REQ-011 In WAIT, fail=1 or the timeout counter reaching WAIT_TIMEOUT SHALL set pending[in_flight] (fail_set), increment msi_fail_count (saturating) and go to BACKOFF.
REQ-012 If sent and fail are asserted together, sent SHALL win.
REQ-013 BACKOFF SHALL last RETRY_DELAY cycles, then go to IDLE.
REQ-014 sent or fail outside WAIT SHALL be ignored.
REQ-015 Ineligible pending bits SHALL remain pending and be issued once mmenable grants them; they are never dropped.
REQ-016 msi_enable[0] deasserting SHALL stop new issues only; an in-flight WAIT SHALL complete normally.
REQ-017 A new irq_in pulse on the in-flight vector during WAIT SHALL re-set the pending bit, so the vector is issued again later.
REQ-018 busy SHALL equal (state != IDLE).

Reset
REQ-019 On rst_user_n=0 (asynchronous): state=IDLE; pending, in_flight, timers and counters =0; last_issued=31; msi_int=0.
REQ-020 Reset asserted mid-WAIT SHALL discard the in-flight request with no retry; a sent/fail arriving after reset SHALL be ignored.
REQ-021 Constant outputs SHALL hold their values in and out of reset.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- enable=1, mm=5, irq_in=32'h1 for 1 cycle -> msi_int=32'h1 for exactly one cycle, 2 edges later; sent -> msi_sent_count=1, irq_pending=0.
- irq_in=32'h0000_0005 in one cycle -> vectors 0 then 2 issued in order, with no overlap between issue and sent.
- fail on vector 3, RETRY_DELAY=16 -> pending[3] re-set, msi_fail_count=1, re-issue no earlier than 17 cycles after fail.
- mm=1, irq_in=32'h0000_0004 -> no issue and pending stays 4; then mm=2 -> vector 2 issued.
- no sent/fail for 1024 cycles in WAIT -> timeout counted as fail and the vector retried; rst_user_n pulsed low in WAIT -> all outputs 0, state IDLE.
